// File: rtl/idelay_lane_sched.sv
// Round-robin IDELAY tap scheduler: walks each lane toward its target in bounded steps.
// Optional macro IDELAY_SCHED_WATCHDOG_EN adds per-lane write counters and a lane_fault output.
module idelay_lane_sched #(
  parameter int N_LANES       = 4,
  parameter int MAX_STEP      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       clk160,
  input  logic                       rstb,
  input  logic [9*N_LANES-1:0]       delay_target_flat,
  input  logic [9*N_LANES-1:0]       delay_out_flat,
  output logic [8:0]                 delay_set_value,
  output logic [N_LANES-1:0]         delay_load,
  output logic [N_LANES-1:0]         lane_ready,
`ifdef IDELAY_SCHED_WATCHDOG_EN
  output logic [N_LANES-1:0]         lane_fault,
`endif
  output logic                       all_ready,
  output logic                       busy,
  output logic [$clog2(N_LANES)-1:0] active_lane
);

  localparam int AW = $clog2(N_LANES);

  typedef enum logic [2:0] {
    S_SCAN,
    S_CAPTURE,
    S_CALC,
    S_LOAD,
    S_SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] lane_q, lane_d, lane_next;
  logic [8:0]    tgt_hold_q, tgt_hold_d;
  logic [8:0]    rb_hold_q, rb_hold_d;
  logic [8:0]    set_q, set_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [8:0]        sel_target, sel_out, step_val;
  logic signed [9:0] diff;
  logic [9:0]        mag;
  logic [N_LANES-1:0] eff_ready;

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      lane_ready[i] = (delay_target_flat[9*i +: 9] == delay_out_flat[9*i +: 9]);
    end
  end

  assign all_ready  = &lane_ready;
  assign sel_target = delay_target_flat[9*int'(lane_q) +: 9];
  assign sel_out    = delay_out_flat[9*int'(lane_q) +: 9];
  assign lane_next  = (lane_q == AW'(N_LANES - 1)) ? '0 : lane_q + 1'b1;

  // Step toward the target, clamped to MAX_STEP; the clamp keeps the result
  // between readback and target, so it can never leave 0..511.
  always_comb begin
    diff = $signed({1'b0, tgt_hold_q}) - $signed({1'b0, rb_hold_q});
    mag  = diff[9] ? 10'(-diff) : 10'(diff);
    if (mag < 10'(MAX_STEP)) begin
      step_val = tgt_hold_q;
    end else if (diff[9]) begin
      step_val = rb_hold_q - 9'(MAX_STEP);
    end else begin
      step_val = rb_hold_q + 9'(MAX_STEP);
    end
  end

`ifdef IDELAY_SCHED_WATCHDOG_EN
  logic [5:0]         wcnt_q [N_LANES];
  logic [N_LANES-1:0] fault_q;

  // NOTE: the counter array is tiny and must start clean, so it is reset like
  // any other register rather than left as uninitialised storage.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      fault_q <= '0;
      for (int i = 0; i < N_LANES; i++) wcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_ready[i]) begin
          wcnt_q[i] <= '0;
        end else if (delay_load[i] && wcnt_q[i] != 6'd63) begin
          wcnt_q[i] <= wcnt_q[i] + 6'd1;
        end
        if (delay_load[i] && wcnt_q[i] == 6'd62) fault_q[i] <= 1'b1;
      end
    end
  end

  assign lane_fault = fault_q;
  assign eff_ready  = lane_ready | fault_q;
`else
  assign eff_ready  = lane_ready;
`endif

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    tgt_hold_d = tgt_hold_q;
    rb_hold_d  = rb_hold_q;
    set_d      = set_q;
    cnt_d      = cnt_q;
    delay_load = '0;
    unique case (state_q)
      S_SCAN: begin
        if (!eff_ready[lane_q]) begin
          state_d = S_CAPTURE;
        end else begin
          lane_d = lane_next;
        end
      end
      S_CAPTURE: begin
        tgt_hold_d = sel_target;
        rb_hold_d  = sel_out;
        state_d    = S_CALC;
      end
      S_CALC: begin
        set_d   = step_val;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // A lane that reached its target on its own this cycle gets no write.
        if (!lane_ready[lane_q]) delay_load[lane_q] = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          lane_d  = lane_next;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_SCAN;
      lane_q     <= '0;
      tgt_hold_q <= '0;
      rb_hold_q  <= '0;
      set_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      tgt_hold_q <= tgt_hold_d;
      rb_hold_q  <= rb_hold_d;
      set_q      <= set_d;
      cnt_q      <= cnt_d;
    end
  end

  assign delay_set_value = set_q;
  assign busy            = (state_q != S_SCAN);
  assign active_lane     = lane_q;

endmodule

// File: tb/tb_idelay_lane_sched.sv
// Self-checking bench for idelay_lane_sched: table-driven single-lane walks,
// a scoreboard of expected loads, plus fairness, target-change and reset sequences.
module tb_idelay_lane_sched;

  localparam int N = 4;

  logic           clk160 = 1'b0;
  logic           rstb;
  logic [9*N-1:0] delay_target_flat, delay_out_flat;
  logic [8:0]     delay_set_value;
  logic [N-1:0]   delay_load, lane_ready;
  logic           all_ready, busy;
  logic [1:0]     active_lane;
`ifdef IDELAY_SCHED_WATCHDOG_EN
  logic [N-1:0]   lane_fault;
`endif

  logic [8:0] tgt [N];
  logic [8:0] rb  [N];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int lane;
    int val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int lane;
    int out;
    int target;
    int n;
    int v[5];
  } vec_t;

  always #5 clk160 = ~clk160;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      delay_target_flat[9*i +: 9] = tgt[i];
      delay_out_flat[9*i +: 9]    = rb[i];
    end
  end

  idelay_lane_sched #(.N_LANES(N), .MAX_STEP(8), .SETTLE_CYCLES(4)) dut (
    .clk160            (clk160),
    .rstb              (rstb),
    .delay_target_flat (delay_target_flat),
    .delay_out_flat    (delay_out_flat),
    .delay_set_value   (delay_set_value),
    .delay_load        (delay_load),
    .lane_ready        (lane_ready),
`ifdef IDELAY_SCHED_WATCHDOG_EN
    .lane_fault        (lane_fault),
`endif
    .all_ready         (all_ready),
    .busy              (busy),
    .active_lane       (active_lane)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load monitor: each strobe pops the scoreboard and updates the lane model.
  always @(negedge clk160) begin
    if (rstb === 1'b1 && delay_load !== '0) begin
      int ln;
      exp_t e;
      ln = -1;
      for (int i = 0; i < N; i++) if (delay_load[i]) ln = i;
      check("load_onehot", int'($onehot(delay_load)), 1);
      if (sb.size() == 0) begin
        check("unexpected_load_lane", ln, -1);
      end else begin
        e = sb.pop_front();
        check("load_lane", ln, e.lane);
        check("load_value", int'(delay_set_value), e.val);
      end
      if (ln >= 0) rb[ln] = delay_set_value;
    end
  end

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk160);
      #1;
      if (sb.size() == 0 && !busy && all_ready) break;
    end
    check(name, int'(k < 3000), 1);
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < N; i++) begin
      tgt[i] = '0;
      rb[i]  = '0;
    end
  endtask

  vec_t tbl[6];

  initial begin
    int a;
    int k;

    tbl[0] = '{0,   0,  20, 3, '{  8,  16,  20, 0, 0}};
    tbl[1] = '{1, 100,  97, 1, '{ 97,   0,   0, 0, 0}};
    tbl[2] = '{2, 300, 280, 3, '{292, 284, 280, 0, 0}};
    tbl[3] = '{3,   5,   0, 1, '{  0,   0,   0, 0, 0}};
    tbl[4] = '{0, 505, 511, 1, '{511,   0,   0, 0, 0}};
    tbl[5] = '{2, 200, 209, 2, '{208, 209,   0, 0, 0}};

    // Reset state
    rstb = 1'b0;
    clear_lanes();
    #12;
    check("rst_active_lane", int'(active_lane), 0);
    check("rst_set_value", int'(delay_set_value), 0);
    check("rst_load", int'(delay_load), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk160);
    rstb = 1'b1;

    // All ready: pointer walks every cycle, never busy
    @(posedge clk160);
    #1;
    a = int'(active_lane);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk160);
      #1;
      check("idle_pointer", int'(active_lane), (a + 1) % N);
      check("idle_busy", int'(busy), 0);
      a = int'(active_lane);
    end

    // Table of single-lane walks
    foreach (tbl[t]) begin
      for (int j = 0; j < tbl[t].n; j++) sb.push_back('{tbl[t].lane, tbl[t].v[j]});
      rb[tbl[t].lane]  = 9'(tbl[t].out);
      tgt[tbl[t].lane] = 9'(tbl[t].target);
      wait_done("vec_timeout");
      check("vec_readback", int'(rb[tbl[t].lane]), tbl[t].target);
      check("vec_lane_ready", int'(lane_ready), 4'hF);
      check("vec_all_ready", int'(all_ready), 1);
    end

    // Fairness: lanes 0 and 3 alternate, one step per pass
    rstb = 1'b0;
    clear_lanes();
    tgt[0] = 9'd40;
    tgt[3] = 9'd40;
    for (int s = 1; s <= 5; s++) begin
      sb.push_back('{0, 8 * s});
      sb.push_back('{3, 8 * s});
    end
    @(negedge clk160);
    rstb = 1'b1;
    wait_done("fair_timeout");
    check("fair_lane0", int'(rb[0]), 40);
    check("fair_lane3", int'(rb[3]), 40);

    // Target change during CALC does not affect the step in flight
    rstb = 1'b0;
    clear_lanes();
    tgt[0] = 9'd50;
    sb.push_back('{0, 8});
    sb.push_back('{0, 10});
    @(negedge clk160);
    rstb = 1'b1;
    @(posedge clk160);
    #1;
    check("first_edge_busy", int'(busy), 1);
    @(posedge clk160);
    #1;
    tgt[0] = 9'd10;
    @(posedge clk160);
    #1;
    check("latency_load", int'(delay_load), 1);
    wait_done("retarget_timeout");
    check("retarget_final", int'(rb[0]), 10);

    // Reset asserted in the middle of a LOAD cycle
    tgt[1] = 9'd100;
    for (k = 0; k < 50; k++) begin
      @(posedge clk160);
      #1;
      if (delay_load != '0) break;
    end
    check("midload_reached", int'(k < 50), 1);
    check("midload_strobe", int'(delay_load), 2);
    check("midload_value", int'(delay_set_value), 8);
    rstb = 1'b0;
    #1;
    check("midload_drop", int'(delay_load), 0);
    check("midload_busy", int'(busy), 0);
    check("midload_lane", int'(active_lane), 0);
    check("midload_setval", int'(delay_set_value), 0);
    clear_lanes();
    @(negedge clk160);
    rstb = 1'b1;
    #1;
    check("release_lane", int'(active_lane), 0);
    check("release_setval", int'(delay_set_value), 0);
    repeat (30) @(posedge clk160);
    #1;
    check("release_idle_busy", int'(busy), 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
